// File: rtl/nor_bank_pkg.sv
// nor_bank shared constants and helpers.
// Mode encodings, default counter width and a constant clog2.
package nor_bank_pkg;

   localparam int MODE_TRANSPORT = 0;
   localparam int MODE_INERTIAL  = 1;
   localparam int CNT_W_DEF      = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v)
            r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/nor_bank_chan.sv
// nor_chan: one NOR channel with transport or inertial clocked delay.
// Optional toggle counter built when NOR_BANK_TOGGLE_CNT_EN is defined.
module nor_chan
   import nor_bank_pkg::*;
#(
   parameter int   FANIN  = 4,
   parameter int   DELAY  = 1,
   parameter int   MODE   = MODE_TRANSPORT,
   parameter logic IC_BIT = 1'b0,
   parameter int   CNT_W  = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FANIN-1:0] in,
   output logic             out
`ifdef NOR_BANK_TOGGLE_CNT_EN
   ,
   output logic [CNT_W-1:0] toggle_cnt
`endif
);

   logic nor_now;
   logic out_nxt;

   assign nor_now = ~|in;

   if (MODE == MODE_INERTIAL) begin : g_inertial
      localparam int CW = clog2(DELAY) + 1;
      localparam logic [CW-1:0] LAST = CW'(DELAY - 1);

      logic [CW-1:0] cnt;
      logic          out_q;

      // out flips only once nor_now has disagreed for DELAY edges
      always_comb begin
         out_nxt = out_q;
         if (nor_now != out_q && cnt == LAST)
            out_nxt = nor_now;
      end

      // disagreement run counter and output register
      always_ff @(posedge clk) begin
         if (rst) begin
            out_q <= IC_BIT;
            cnt   <= '0;
         end else begin
            out_q <= out_nxt;
            if (nor_now == out_q || cnt == LAST)
               cnt <= '0;
            else
               cnt <= cnt + CW'(1);
         end
      end

      assign out = out_q;
   end else begin : g_transport
      logic [DELAY-1:0] sr;
      logic [DELAY:0]   tap;

      assign tap     = {sr, nor_now};
      assign out_nxt = tap[DELAY-1];
      assign out     = tap[DELAY];

      // plain shift line, every sample survives DELAY edges
      always_ff @(posedge clk) begin
         if (rst)
            sr <= {DELAY{IC_BIT}};
         else
            sr <= tap[DELAY-1:0];
      end
   end

`ifdef NOR_BANK_TOGGLE_CNT_EN
   logic [CNT_W-1:0] tcnt;

   // count real output transitions, saturating; the reset load is not one
   always_ff @(posedge clk) begin
      if (rst)
         tcnt <= '0;
      else if (out_nxt != out && tcnt != '1)
         tcnt <= tcnt + CNT_W'(1);
   end

   assign toggle_cnt = tcnt;
`else
   logic unused_cfg;
   assign unused_cfg = out_nxt ^ (CNT_W > 0);
`endif

endmodule

// File: rtl/nor_bank.sv
// nor_bank: CH independent FANIN-input NOR channels with clocked delay.
// Define NOR_BANK_TOGGLE_CNT_EN to add per-channel toggle counters.
module nor_bank
   import nor_bank_pkg::*;
#(
   parameter int          CH    = 2,
   parameter int          FANIN = 4,
   parameter int          DELAY = 1,
   parameter int          MODE  = MODE_TRANSPORT,
   parameter logic [CH-1:0] IC  = {CH{1'b0}},
   parameter int          CNT_W = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                vcc,
   input  logic                gnd,
   input  logic [CH*FANIN-1:0] in,
   output logic [CH-1:0]       out
`ifdef NOR_BANK_TOGGLE_CNT_EN
   ,
   output logic [CH*CNT_W-1:0] toggle_cnt
`endif
);

   logic unused_pwr;
   assign unused_pwr = vcc ^ gnd;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      nor_chan #(
         .FANIN  (FANIN),
         .DELAY  (DELAY),
         .MODE   (MODE),
         .IC_BIT (IC[i]),
         .CNT_W  (CNT_W)
      ) u_chan (
         .clk        (clk),
         .rst        (rst),
         .in         (in[i*FANIN +: FANIN]),
`ifdef NOR_BANK_TOGGLE_CNT_EN
         .toggle_cnt (toggle_cnt[i*CNT_W +: CNT_W]),
`endif
         .out        (out[i])
      );
   end

endmodule

// File: tb/tb_nor_bank.sv
// tb_nor_bank: directed and random checks of several nor_bank builds.
// Expected outputs come from a sample-history model of the delay rules.
module tb_nor_bank;

   localparam int NI = 5;
   localparam int P_CH[NI] = '{2, 2, 4, 1, 4};
   localparam int P_FI[NI] = '{4, 4, 2, 4, 2};
   localparam int P_DL[NI] = '{3, 3, 1, 4, 1};
   localparam int P_MD[NI] = '{0, 1, 0, 1, 1};
   localparam int P_IC[NI] = '{2, 1, 0, 1, 0};
   localparam int CW = 3;
   localparam int TMAX = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       vcc = 1'b1;
   logic       gnd = 1'b0;
   logic [7:0] in_t = '0;
   logic [7:0] in_i = '0;
   logic [7:0] in_c = '0;
   logic [3:0] in_d = '0;

   logic [1:0] o0, o1;
   logic [3:0] o2, o4;
   logic [0:0] o3;
`ifdef NOR_BANK_TOGGLE_CNT_EN
   logic [5:0]  t0, t1;
   logic [11:0] t2, t4;
   logic [2:0]  t3;
`endif

   bit       mo[NI][4];
   bit [7:0] hs[NI][4];
   int       ns[NI][4];
   int       tm[NI][4];
   int       total = 0;
   int       bad = 0;

   always #5 clk = ~clk;

   nor_bank #(.CH(2), .FANIN(4), .DELAY(3), .MODE(0),
              .IC(2'b10), .CNT_W(CW)) u0 (
      .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .in(in_t),
`ifdef NOR_BANK_TOGGLE_CNT_EN
      .toggle_cnt(t0),
`endif
      .out(o0));

   nor_bank #(.CH(2), .FANIN(4), .DELAY(3), .MODE(1),
              .IC(2'b01), .CNT_W(CW)) u1 (
      .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .in(in_i),
`ifdef NOR_BANK_TOGGLE_CNT_EN
      .toggle_cnt(t1),
`endif
      .out(o1));

   nor_bank #(.CH(4), .FANIN(2), .DELAY(1), .MODE(0),
              .IC(4'b0000), .CNT_W(CW)) u2 (
      .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .in(in_c),
`ifdef NOR_BANK_TOGGLE_CNT_EN
      .toggle_cnt(t2),
`endif
      .out(o2));

   nor_bank #(.CH(1), .FANIN(4), .DELAY(4), .MODE(1),
              .IC(1'b1), .CNT_W(CW)) u3 (
      .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .in(in_d),
`ifdef NOR_BANK_TOGGLE_CNT_EN
      .toggle_cnt(t3),
`endif
      .out(o3));

   nor_bank #(.CH(4), .FANIN(2), .DELAY(1), .MODE(1),
              .IC(4'b0000), .CNT_W(CW)) u4 (
      .clk(clk), .rst(rst), .vcc(vcc), .gnd(gnd), .in(in_c),
`ifdef NOR_BANK_TOGGLE_CNT_EN
      .toggle_cnt(t4),
`endif
      .out(o4));

   function automatic logic [31:0] obs(input int k);
      case (k)
         0: return 32'(o0);
         1: return 32'(o1);
         2: return 32'(o2);
         3: return 32'(o3);
         default: return 32'(o4);
      endcase
   endfunction

`ifdef NOR_BANK_TOGGLE_CNT_EN
   function automatic logic [31:0] tobs(input int k);
      case (k)
         0: return 32'(t0);
         1: return 32'(t1);
         2: return 32'(t2);
         3: return 32'(t3);
         default: return 32'(t4);
      endcase
   endfunction
`endif

   task automatic check(input string tag, input logic [31:0] o,
                        input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // one clock: drive, advance the model by the rules, compare all builds
   task automatic cyc(input logic r, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] cc,
                      input logic [3:0] d);
      logic [7:0]  iv[NI];
      logic [31:0] ev;
      logic [31:0] et;
      bit          s, nv, chg;
      int          dl;
      @(negedge clk);
      rst  = r;
      in_t = a;
      in_i = b;
      in_c = cc;
      in_d = d;
      iv = '{a, b, cc, {4'b0, d}, cc};
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
         dl = P_DL[k];
         for (int q = 0; q < P_CH[k]; q++) begin
            if (r) begin
               mo[k][q] = ((P_IC[k] >> q) & 1) != 0;
               hs[k][q] = '0;
               ns[k][q] = 0;
               tm[k][q] = 0;
            end else begin
               s = ((iv[k] >> (q * P_FI[k])) &
                    ((8'd1 << P_FI[k]) - 8'd1)) == 8'd0;
               hs[k][q] = {hs[k][q][6:0], s};
               if (ns[k][q] < 100)
                  ns[k][q]++;
               if (P_MD[k] == 0) begin
                  if (ns[k][q] >= dl)
                     nv = hs[k][q][dl-1];
                  else
                     nv = ((P_IC[k] >> q) & 1) != 0;
               end else begin
                  chg = ns[k][q] >= dl;
                  for (int j = 0; j < dl; j++)
                     if (hs[k][q][j] == mo[k][q])
                        chg = 1'b0;
                  nv = chg ? ~mo[k][q] : mo[k][q];
               end
               if (nv != mo[k][q] && tm[k][q] < TMAX)
                  tm[k][q]++;
               mo[k][q] = nv;
            end
         end
      end
      #1;
      for (int k = 0; k < NI; k++) begin
         ev = '0;
         et = '0;
         for (int q = 0; q < P_CH[k]; q++) begin
            ev[q] = mo[k][q];
            et = et | (32'(tm[k][q]) << (q * CW));
         end
         check($sformatf("out%0d", k), obs(k), ev);
`ifdef NOR_BANK_TOGGLE_CNT_EN
         check($sformatf("tog%0d", k), tobs(k), et);
`endif
      end
   endtask

   logic [7:0] ra, rb, rc;
   logic [3:0] rd;
   logic [1:0] exp_tr[5];

   initial begin
      // reset with IC loaded, held two edges
      cyc(1'b1, 8'h00, 8'h00, 8'h00, 4'h0);
      cyc(1'b1, 8'h00, 8'h00, 8'h00, 4'h0);
      check("rst_ic0", 32'(o0), 32'h2);
      check("rst_ic2", 32'(o2), 32'h0);
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);
      check("first_edge_d1", 32'(o2), 32'hf);
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);
      check("d3_wait", 32'(o0), 32'h2);
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);
      check("d3_settle", 32'(o0), 32'h3);

      // transport: step on channel 0 lands on the third edge
      exp_tr = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
      for (int e = 0; e < 5; e++) begin
         cyc(1'b0, 8'h04, 8'h00, 8'h00, 4'h0);
         check($sformatf("tr_step%0d", e), 32'(o0), 32'(exp_tr[e]));
      end
      for (int e = 0; e < 4; e++)
         cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);
      // one-cycle pulse survives as a one-cycle pulse
      cyc(1'b0, 8'h01, 8'h00, 8'h00, 4'h0);
      exp_tr = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b11};
      check("tr_pulse0", 32'(o0), 32'(exp_tr[0]));
      for (int e = 1; e < 5; e++) begin
         cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);
         check($sformatf("tr_pulse%0d", e), 32'(o0), 32'(exp_tr[e]));
      end

      // inertial: a two-edge disturbance is absorbed
      cyc(1'b0, 8'h00, 8'h08, 8'h00, 4'h0);
      cyc(1'b0, 8'h00, 8'h08, 8'h00, 4'h0);
      check("inr_short", 32'(o1[0]), 32'h1);
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);
      check("inr_absorb", 32'(o1[0]), 32'h1);
      cyc(1'b0, 8'h00, 8'h08, 8'h00, 4'h0);
      cyc(1'b0, 8'h00, 8'h08, 8'h00, 4'h0);
      check("inr_hold2", 32'(o1[0]), 32'h1);
      cyc(1'b0, 8'h00, 8'h08, 8'h00, 4'h0);
      check("inr_hold3", 32'(o1[0]), 32'h0);
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);

      // reset mid-count restarts the inertial window
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h8);
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h8);
      check("mid_pre", 32'(o3), 32'h1);
      cyc(1'b1, 8'h00, 8'h00, 8'h00, 4'h8);
      check("mid_rst_d", 32'(o3), 32'h1);
      check("mid_rst_i", 32'(o1), 32'h1);
      for (int e = 0; e < 3; e++) begin
         cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h8);
         check($sformatf("mid_wait%0d", e), 32'(o3), 32'h1);
      end
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h8);
      check("mid_flip", 32'(o3), 32'h0);

      // channel independence: only channel 2 moves
      cyc(1'b0, 8'h00, 8'h00, 8'h00, 4'h0);
      cyc(1'b0, 8'h00, 8'h00, 8'h10, 4'h0);
      check("indep_t", 32'(o2), 32'hb);
      check("indep_i", 32'(o4), 32'hb);

      // toggle counter saturation, then cleared by reset
      cyc(1'b1, 8'h00, 8'h00, 8'h00, 4'h0);
      for (int e = 0; e < 20; e++)
         cyc(1'b0, 8'h00, 8'h00, (e % 2 == 0) ? 8'h01 : 8'h00, 4'h0);
`ifdef NOR_BANK_TOGGLE_CNT_EN
      check("tog_sat", 32'(t2[2:0]), 32'h7);
`endif
      cyc(1'b1, 8'h00, 8'h00, 8'h00, 4'h0);
      check("tog_rst_out", 32'(o2), 32'h0);
`ifdef NOR_BANK_TOGGLE_CNT_EN
      check("tog_rst", 32'(t2), 32'h0);
`endif

      // random phase with held input runs and occasional reset
      ra = '0;
      rb = '0;
      rc = '0;
      rd = '0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            ra = 8'($urandom & $urandom);
            rb = 8'($urandom & $urandom);
            rc = 8'($urandom & $urandom);
            rd = 4'($urandom & $urandom);
         end
         cyc(($urandom_range(0, 39) == 0), ra, rb, rc, rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nor_bank.md
Name: nor_bank

Overview:
- Parametrised multi-channel NOR gate bank with configurable fan-in and clocked propagation delay.
- Each output updates on clk edges from its channel's input group, using transport or inertial (glitch-rejecting) delay.
- Generalises the fixed dual 4-input NOR package model.
- Used as the building block for generated 74HC-series NOR packages and wide-logic cells in the AGC gate-level simulation.

Parameters:
- CH, 2, number of independent NOR channels (>=1).
- FANIN, 4, inputs per channel (>=1); unused inputs tied to gnd by the instantiating package.
- DELAY, 1, propagation delay in clk cycles (>=1).
- MODE, 0, 0 = transport delay, 1 = inertial delay.
- IC, {CH{1'b0}}, CH-bit vector of per-channel output values loaded by rst; bit i belongs to channel i.
- CNT_W, 16, toggle counter width; only meaningful when NOR_BANK_TOGGLE_CNT_EN is defined.

Ports:
- clk  input  1  simulation clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- vcc  input  1  power pin; functionally ignored.
- gnd  input  1  ground pin; functionally ignored.
- in  input  CH*FANIN  channel i uses bits in[i*FANIN +: FANIN].
- out  output  CH  out[i] is the delayed NOR of channel i.
- toggle_cnt  output  CH*CNT_W  present only with NOR_BANK_TOGGLE_CNT_EN; channel i uses bits [i*CNT_W +: CNT_W].

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high: sampled on the rising clk edge only.
- Per-channel nor_now[i] = ~|in[i*FANIN +: FANIN]. This is combinational, internal only, and never drives out directly.
- Reset:
  - On any edge with rst=1: out[i] <= IC[i].
  - All delay-line stages <= IC[i].
  - All inertial counters <= 0.
  - toggle_cnt <= 0.
  - rst takes priority over every other update, including mid-transition or mid-count; after rst drops, evaluation restarts from IC.
- MODE=0 (transport):
  - Per channel, a DELAY-deep shift register; stage0 <= nor_now each edge and out = last stage.
  - Every input change, however short, appears at out exactly DELAY edges later.
  - A one-cycle pulse is preserved as a one-cycle pulse.
  - DELAY=1 gives out <= nor_now on the next edge.
- MODE=1 (inertial):
  - Per channel, counter cnt of width clog2(DELAY)+1.
  - Each edge, if nor_now == out: cnt <= 0.
  - Else if cnt == DELAY-1: out <= nor_now and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Net effect: out follows nor_now only after it has differed from out for DELAY consecutive edges; shorter pulses are absorbed entirely.
  - DELAY=1 behaves identically to MODE=0 with DELAY=1.
- Channel independence: channels never interact. Simultaneous changes on all channels are processed in parallel with identical timing.
- X/Z inputs: nor_now follows Verilog semantics. out may go X; no X-suppression is performed.
- Latency: min DELAY edges from input change to output change in both modes.

Optional Feature:
- Macro: NOR_BANK_TOGGLE_CNT_EN.
- Defined:
  - toggle_cnt port exists.
  - Each edge where out[i] changes value (rst not asserted), toggle_cnt[i] increments.
  - Counter saturates at 2^CNT_W-1 and never wraps.
  - Cleared by rst.
  - The reset-induced load of IC does not count as a toggle.
  - Used for switching-activity/power estimates.
- Undefined:
  - Port and counters are absent.
  - out behaviour is bit-identical to the defined build.

Decomposition:
- Shared package nor_bank_pkg holds:
  - MODE_TRANSPORT=0 and MODE_INERTIAL=1 constants;
  - a clog2 function;
  - the default CNT_W.
- Sub-module nor_chan: one channel carrying FANIN, DELAY, MODE, IC_BIT and the optional toggle counter. nor_bank instantiates it CH times in a generate loop.
- Package wrappers (e.g. quad 2-input, dual 4-input) are thin instantiations of nor_bank.

Test Plan:
- Reset/IC: CH=2, IC=2'b10, in=all 0, rst high 2 edges -> out=2'b10 and stays 2'b10 while rst=1 despite NOR=1. On the first edge after rst drops, out becomes 2'b11 (DELAY=1).
- Transport delay: CH=1, FANIN=4, DELAY=3, MODE=0; in goes from 4'b0000 to 4'b0100 at edge 10 -> out falls 1->0 at edge 13. A one-cycle pulse in=4'b0001 at edge 20 gives out=0 exactly at edge 23 only.
- Inertial rejection: DELAY=3, MODE=1, out=1; in=4'b1000 held 2 cycles then 0 -> out stays 1 and cnt returns to 0. Held 3 cycles -> out=0 at the 3rd edge.
- Reset mid-operation: MODE=1, DELAY=4, disturbance held for 2 edges, then rst for 1 edge -> out=IC. The following disturbance needs a full 4 edges before out changes.
- Channel independence: CH=4, FANIN=2, IC=0, rst applied then released with all inputs low; then drive in channel 2 only -> only out[2] changes, and out[0], out[1], out[3] remain 1.
- Toggle counter (macro defined, CNT_W=3): toggle out 9 times -> toggle_cnt=7 (saturated). rst -> 0; the IC load does not increment it. Undefined build: same out trace.
